// File: rtl/gate_timer_fsm_if.sv
// gate_timer_fsm_if
// Groups the barrier sequencer's stimulus inputs and status outputs.
//   tick_in          : divided clock from the divide-by-5 divider (level)
//   access_granted   : one-cycle entry authorisation pulse
//   vehicle_present  : high while a vehicle is under the barrier
//   motor_open       : drive barrier up
//   motor_close      : drive barrier down
//   gate_open        : barrier fully raised
//   busy             : sequencer not idle
//   cycle_done       : one-cycle pulse when a close completes
//   state            : IDLE=0, OPENING=1, HOLD=2, CLOSING=3
// master : the side that drives tick/grant/sensor (system or bench)
// slave  : the sequencer itself
interface gate_timer_fsm_if;
  logic       tick_in;
  logic       access_granted;
  logic       vehicle_present;
  logic       motor_open;
  logic       motor_close;
  logic       gate_open;
  logic       busy;
  logic       cycle_done;
  logic [1:0] state;

  modport master (
    output tick_in, access_granted, vehicle_present,
    input  motor_open, motor_close, gate_open, busy, cycle_done, state
  );

  modport slave (
    input  tick_in, access_granted, vehicle_present,
    output motor_open, motor_close, gate_open, busy, cycle_done, state
  );
endinterface

// File: rtl/gate_timer_fsm.sv
// gate_timer_fsm
// Barrier-gate sequencer. Edge-detects the divided clock as a tick source
// and times the OPENING, HOLD and CLOSING phases of the barrier motor in
// whole tick pulses, reacting to access grants and the vehicle sensor.
// Ports:
//   clk   : system clock, all logic on its rising edge
//   reset : synchronous, active-high
//   bus   : gate_timer_fsm_if.slave (tick/grant/sensor in, motor/status out)
module gate_timer_fsm #(
  parameter int OPEN_TICKS  = 4,
  parameter int HOLD_TICKS  = 10,
  parameter int CLOSE_TICKS = 4,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           reset,
  gate_timer_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    HOLD    = 2'd2,
    CLOSING = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             tick_d;
  logic             cycle_done_q, cycle_done_n;
  logic             tick_pulse;

  // One pulse per rising edge of the divided clock. tick_d resets high so a
  // tick_in already high when reset releases is not taken as an edge.
  assign tick_pulse = bus.tick_in & ~tick_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tick_d       <= 1'b1;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      tick_d       <= bus.tick_in;
      cycle_done_q <= cycle_done_n;
    end
  end

  // Terminal compare is evaluated before the increment, so the counter
  // never reaches N and never wraps; every state entry clears it.
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    cycle_done_n = 1'b0;
    case (state_q)
      IDLE: begin
        // A tick coincident with the grant is deliberately not counted.
        if (bus.access_granted) begin
          state_n = OPENING;
          cnt_n   = '0;
        end
      end
      OPENING: begin
        if (tick_pulse) begin
          if (cnt_q == OPEN_LAST) begin
            state_n = HOLD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_ONE;
          end
        end
      end
      HOLD: begin
        // A present vehicle or a fresh grant restarts the hold window.
        if (bus.vehicle_present || bus.access_granted) begin
          cnt_n = '0;
        end else if (tick_pulse) begin
          if (cnt_q == HOLD_LAST) begin
            state_n = CLOSING;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_ONE;
          end
        end
      end
      CLOSING: begin
        // Safety reversal wins over completion on the same cycle.
        if (bus.vehicle_present || bus.access_granted) begin
          state_n = OPENING;
          cnt_n   = '0;
        end else if (tick_pulse) begin
          if (cnt_q == CLOSE_LAST) begin
            state_n      = IDLE;
            cnt_n        = '0;
            cycle_done_n = 1'b1;
          end else begin
            cnt_n = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Moore outputs straight from the state register.
  assign bus.motor_open  = (state_q == OPENING);
  assign bus.motor_close = (state_q == CLOSING);
  assign bus.gate_open   = (state_q == HOLD);
  assign bus.busy        = (state_q != IDLE);
  assign bus.cycle_done  = cycle_done_q;
  assign bus.state       = state_q;

endmodule

// File: doc/gate_timer_fsm.md
Name: gate_timer_fsm

Overview:
- Barrier-gate sequencer for the vehicle access system.
- Sits directly downstream of the divide-by-5 clock divider.
- Samples the divided clock as a tick source in the system clock domain and times the open, hold and close phases of the barrier motor.
- Reacts to access-grant pulses and the vehicle-presence sensor.

Parameters:
- OPEN_TICKS, 4: tick pulses spent in OPENING (must be >= 1).
- HOLD_TICKS, 10: vehicle-free tick pulses spent in HOLD before closing (must be >= 1).
- CLOSE_TICKS, 4: tick pulses spent in CLOSING (must be >= 1).
- CNT_W, 8: phase counter width; must represent max(OPEN_TICKS, HOLD_TICKS, CLOSE_TICKS)-1.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- tick_in, input, 1: divided clock from the divider, treated as a level signal.
- access_granted, input, 1: one-cycle pulse authorising entry.
- vehicle_present, input, 1: level, high while a vehicle is under the barrier.
- motor_open, output, 1: drive barrier up.
- motor_close, output, 1: drive barrier down.
- gate_open, output, 1: barrier fully raised (HOLD).
- busy, output, 1: state != IDLE.
- cycle_done, output, 1: one-cycle pulse on CLOSING -> IDLE.
- state, output, 2: IDLE=0, OPENING=1, HOLD=2, CLOSING=3.

Behaviour:
- Reset (synchronous, active-high) forces the following on the next clk edge:
  - state=IDLE, cnt=0.
  - All outputs 0.
  - Tick-edge register tick_d=1, so a tick_in already high at reset release is not counted.
- Tick detection:
  - tick_pulse = tick_in & ~tick_d; tick_d <= tick_in every cycle.
  - One pulse per rising edge of tick_in.
- Outputs are Moore-decoded from the state register:
  - motor_open=(OPENING), motor_close=(CLOSING), gate_open=(HOLD), busy=(state!=IDLE).
  - Outputs change in the cycle after the transition-causing input.
- cycle_done is a registered output: high for exactly the one cycle in which state first reads IDLE after CLOSING.
- Phase counter cnt:
  - Increments only on tick_pulse.
  - Cleared to 0 on every state entry.
  - A phase ends on the cycle where tick_pulse=1 and cnt==N-1, so each phase lasts exactly N tick pulses.
- IDLE:
  - access_granted -> OPENING next cycle, cnt=0.
  - A tick_pulse coincident with the grant is not counted.
  - vehicle_present alone does nothing.
- OPENING:
  - Ends after OPEN_TICKS tick pulses -> HOLD.
  - access_granted and vehicle_present are ignored.
- HOLD:
  - vehicle_present=1 holds cnt at 0; tick pulses are not counted.
  - access_granted clears cnt to 0 (restarts the hold).
  - After HOLD_TICKS tick pulses with vehicle_present=0 -> CLOSING.
  - If vehicle_present=1 on the terminal tick cycle, stay in HOLD with cnt=0.
- CLOSING:
  - vehicle_present=1 or access_granted=1 -> OPENING next cycle, cnt=0; the full OPEN_TICKS applies (safety reversal).
  - The reversal has priority over completion on the same cycle.
  - Otherwise, after CLOSE_TICKS tick pulses -> IDLE, and cycle_done is pulsed.
- Reset mid-operation: IDLE on the next edge from any state; motors de-asserted that same edge; no cycle_done.
- The counter never wraps: terminal compare precedes increment.

Test Plan:
- Reset checks:
  - reset for 3 cycles with tick_in=1 held across release -> all outputs 0, state=0.
  - The first tick_pulse appears only after tick_in goes 0 then 1.
- Normal cycle:
  - tick_in = divide-by-5 waveform (tick every 5 clk); access_granted pulse, vehicle_present=0.
  - motor_open high from the next cycle for 4 ticks (~20 clk); gate_open for 10 ticks; motor_close for 4 ticks.
  - cycle_done is a single-cycle pulse; then IDLE.
- Vehicle hold:
  - vehicle_present=1 asserted at hold tick 7, held 30 clk -> state stays 2.
  - After release, exactly 10 further ticks before CLOSING.
- Safety reversal:
  - vehicle_present=1 at close tick 2 -> next cycle state=1, motor_close=0, motor_open=1.
  - Full 4-tick OPENING, then HOLD.
- Grant priority:
  - access_granted during OPENING -> no effect.
  - access_granted at hold tick 9 -> 10 new ticks counted.
  - access_granted coincident with tick_pulse in IDLE -> OPENING still lasts 4 ticks.
- Mid-operation reset: reset during CLOSING -> state=0, motor_close=0 next cycle, cycle_done stays 0.
